nird_hist_accum: RTL and testbench

- Downstream consumer of the NI stage. Takes the eight per-pixel NI comparison bits and their done/progress strobes.
- Forms an 8-bit NI code per pixel and accumulates a per-frame histogram of codes in on-chip RAM.
- At frame end, streams the bins out over a valid/ready interface, clearing each bin as it is read.
- Feeds the NIRD feature-vector output / host DMA.

---
 rtl/nird_pkg.sv | 51 +++++
 rtl/ni_hist_ram.sv | 37 +++
 rtl/nird_hist_accum.sv | 208 ++++++++++++++++++++
 tb/tb_nird_hist_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nird_pkg.sv
// nird_pkg: shared constants, histogram controller state type and the optional
// uniform-pattern code map for the NIRD histogram slice.
//
// Optional feature macro: NI_UNIFORM_MAP_EN
//   When defined, provides ni_uniform_map(), which folds the 8-bit NI code
//   into 59 bins (58 uniform patterns plus one catch-all bin).
package nird_pkg;

    localparam int NI_CODE_W     = 8;
    localparam int NUM_BINS_FULL = 256;
    localparam int NUM_BINS_UNI  = 59;

    // S_DRAIN3 is only visited when the uniform map adds its extra pipeline stage.
    typedef enum logic [2:0] {
        S_CLEAR  = 3'd0,
        S_ACCUM  = 3'd1,
        S_DRAIN1 = 3'd2,
        S_DRAIN2 = 3'd3,
        S_DRAIN3 = 3'd4,
        S_RD     = 3'd5,
        S_RESP   = 3'd6
    } hist_state_t;

`ifdef NI_UNIFORM_MAP_EN
    // A code is uniform when it has at most two 0/1 transitions around the circle.
    function automatic logic ni_is_uniform(input logic [NI_CODE_W-1:0] code);
        logic [NI_CODE_W-1:0] diff;
        diff = code ^ {code[0], code[NI_CODE_W-1:1]};
        return ($countones(diff) <= 2);
    endfunction

    // Uniform codes get their rank among uniform codes (ascending code order);
    // everything else lands in the last bin.
    function automatic logic [NI_CODE_W-1:0] ni_uniform_map(input logic [NI_CODE_W-1:0] code);
        logic [NI_CODE_W-1:0] idx;
        logic [NI_CODE_W-1:0] c;
        idx = '0;
        if (!ni_is_uniform(code)) begin
            return NI_CODE_W'(NUM_BINS_UNI - 1);
        end
        for (int i = 0; i < NUM_BINS_FULL; i++) begin
            c = i[NI_CODE_W-1:0];
            if ((c < code) && ni_is_uniform(c)) begin
                idx = idx + NI_CODE_W'(1);
            end
        end
        return idx;
    endfunction
`endif

endpackage

// File: rtl/ni_hist_ram.sv
// ni_hist_ram: simple dual-port histogram bin storage.
//   One write port, one synchronous read port with read enable. A read and a
//   write to the same address in the same cycle return the old contents
//   (read-first). The array has no reset; the owner clears it explicitly.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr      read request; rdata updates on the following edge
//   rdata         registered read data, held while re is low
module ni_hist_ram
    import nird_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int COUNT_W = 20,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [COUNT_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [COUNT_W-1:0] rdata
);

    logic [COUNT_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/nird_hist_accum.sv
// nird_hist_accum: per-frame histogram of NI codes.
//   After reset the bin RAM is cleared (one bin per cycle), then pixels are
//   accumulated at full rate through a read/increment/write pipeline. A frame
//   end pulse drains the pipeline and streams every bin out over valid/ready,
//   zeroing each bin as it is accepted, then returns to accumulation.
// Optional feature macro: NI_UNIFORM_MAP_EN (59 uniform-pattern bins, one
//   extra pipeline stage and one extra drain cycle).
// Ports:
//   clk, rst (async, active-low)
//   done_i, bit1_i..bit8_i   pixel strobe and code bits (bit1_i is the LSB)
//   progress_done_i          end-of-frame pulse
//   hist_ready_i / hist_valid_o, hist_bin_o, hist_count_o, hist_last_o  readout
//   ready_o                  high while accumulating
//   dropped_o                sticky: a pixel arrived while not accumulating
module nird_hist_accum #(
    parameter int COUNT_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               done_i,
    input  logic               progress_done_i,
    input  logic               bit1_i,
    input  logic               bit2_i,
    input  logic               bit3_i,
    input  logic               bit4_i,
    input  logic               bit5_i,
    input  logic               bit6_i,
    input  logic               bit7_i,
    input  logic               bit8_i,
    input  logic               hist_ready_i,
    output logic               hist_valid_o,
    output logic [7:0]         hist_bin_o,
    output logic [COUNT_W-1:0] hist_count_o,
    output logic               hist_last_o,
    output logic               ready_o,
    output logic               dropped_o
);
    import nird_pkg::*;

`ifdef NI_UNIFORM_MAP_EN
    localparam int NUM_BINS = NUM_BINS_UNI;
`else
    localparam int NUM_BINS = NUM_BINS_FULL;
`endif
    localparam logic [NI_CODE_W-1:0] LAST_BIN = NI_CODE_W'(NUM_BINS - 1);
    localparam logic [COUNT_W-1:0]   CNT_MAX  = '1;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + COUNT_W'(1);
    endfunction

    hist_state_t state, state_nxt;
    logic [NI_CODE_W-1:0] clr_addr, bin;
    logic                 dropped;

    logic                 accept;
    logic [NI_CODE_W-1:0] code_in;
    logic                 vld_p0;
    logic [NI_CODE_W-1:0] code_p0;
    logic                 rd_vld;
    logic [NI_CODE_W-1:0] rd_addr;
    logic                 vld_p2, byp_p2;
    logic [NI_CODE_W-1:0] addr_p2;
    logic [COUNT_W-1:0]   byp_val_p2, inc_p2;

    logic                 ram_we, ram_re;
    logic [NI_CODE_W-1:0] ram_waddr, ram_raddr;
    logic [COUNT_W-1:0]   ram_wdata, ram_rdata;

    assign code_in = {bit8_i, bit7_i, bit6_i, bit5_i, bit4_i, bit3_i, bit2_i, bit1_i};
    assign accept  = done_i && (state == S_ACCUM);

    // ---- stage A: capture pixel code ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) code_p0 <= code_in;
    end

`ifdef NI_UNIFORM_MAP_EN
    // ---- stage M: uniform-pattern map ----
    logic                 vld_p1;
    logic [NI_CODE_W-1:0] addr_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p1 <= 1'b0;
        else      vld_p1 <= vld_p0;
    end

    always_ff @(posedge clk) begin
        addr_p1 <= ni_uniform_map(code_p0);
    end

    assign rd_vld  = vld_p1;
    assign rd_addr = addr_p1;
`else
    assign rd_vld  = vld_p0;
    assign rd_addr = code_p0;
`endif

    // ---- stage B: RAM read issued; stage C: increment and write back ----
    // The RAM is read-first, so a read of the address being written this cycle
    // returns the stale count; capture the value being written instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p2 <= 1'b0;
        else      vld_p2 <= rd_vld;
    end

    always_ff @(posedge clk) begin
        addr_p2    <= rd_addr;
        byp_p2     <= vld_p2 && (addr_p2 == rd_addr);
        byp_val_p2 <= inc_p2;
    end

    assign inc_p2 = sat_inc(byp_p2 ? byp_val_p2 : ram_rdata);

    // RAM port steering; the pipeline drains before CLEAR/RESP writes could collide.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = addr_p2;
        ram_wdata = inc_p2;
        ram_re    = 1'b0;
        ram_raddr = rd_addr;
        if (vld_p2) begin
            ram_we = 1'b1;
        end else if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else if ((state == S_RESP) && hist_ready_i) begin
            ram_we    = 1'b1;
            ram_waddr = bin;
            ram_wdata = '0;
        end
        if (state == S_RD) begin
            ram_re    = 1'b1;
            ram_raddr = bin;
        end else if (rd_vld) begin
            ram_re = 1'b1;
        end
    end

    ni_hist_ram #(
        .DEPTH   (NUM_BINS),
        .COUNT_W (COUNT_W),
        .ADDR_W  (NI_CODE_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_CLEAR;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR:  if (clr_addr == LAST_BIN) state_nxt = S_ACCUM;
            S_ACCUM:  if (progress_done_i) state_nxt = S_DRAIN1;
            S_DRAIN1: state_nxt = S_DRAIN2;
`ifdef NI_UNIFORM_MAP_EN
            S_DRAIN2: state_nxt = S_DRAIN3;
            S_DRAIN3: state_nxt = S_RD;
`else
            S_DRAIN2: state_nxt = S_RD;
`endif
            S_RD:     state_nxt = S_RESP;
            S_RESP:   if (hist_ready_i) state_nxt = (bin == LAST_BIN) ? S_ACCUM : S_RD;
            default:  state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_addr <= '0;
            bin      <= '0;
            dropped  <= 1'b0;
        end else begin
            if ((state == S_CLEAR) && (clr_addr != LAST_BIN)) begin
                clr_addr <= clr_addr + NI_CODE_W'(1);
            end
            if ((state == S_RESP) && hist_ready_i) begin
                bin <= (bin == LAST_BIN) ? '0 : bin + NI_CODE_W'(1);
            end
            if (done_i && (state != S_ACCUM)) begin
                dropped <= 1'b1;
            end
        end
    end

    assign hist_valid_o = (state == S_RESP);
    assign hist_bin_o   = bin;
    assign hist_count_o = (state == S_RESP) ? ram_rdata : '0;
    assign hist_last_o  = (state == S_RESP) && (bin == LAST_BIN);
    assign ready_o      = (state == S_ACCUM);
    assign dropped_o    = dropped;

endmodule

// File: tb/tb_nird_hist_accum.sv
module tb_nird_hist_accum;

    localparam int CW = 4;
    localparam int NB = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          done_i = 1'b0;
    logic          progress_done_i = 1'b0;
    logic          bit1_i = 1'b0, bit2_i = 1'b0, bit3_i = 1'b0, bit4_i = 1'b0;
    logic          bit5_i = 1'b0, bit6_i = 1'b0, bit7_i = 1'b0, bit8_i = 1'b0;
    logic          hist_ready_i = 1'b0;
    logic          hist_valid_o;
    logic [7:0]    hist_bin_o;
    logic [CW-1:0] hist_count_o;
    logic          hist_last_o;
    logic          ready_o;
    logic          dropped_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [CW-1:0] exp_cnt [NB];
    logic [7:0]    pix [24];

    nird_hist_accum #(.COUNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .done_i          (done_i),
        .progress_done_i (progress_done_i),
        .bit1_i          (bit1_i),
        .bit2_i          (bit2_i),
        .bit3_i          (bit3_i),
        .bit4_i          (bit4_i),
        .bit5_i          (bit5_i),
        .bit6_i          (bit6_i),
        .bit7_i          (bit7_i),
        .bit8_i          (bit8_i),
        .hist_ready_i    (hist_ready_i),
        .hist_valid_o    (hist_valid_o),
        .hist_bin_o      (hist_bin_o),
        .hist_count_o    (hist_count_o),
        .hist_last_o     (hist_last_o),
        .ready_o         (ready_o),
        .dropped_o       (dropped_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_code(input logic [7:0] c);
        {bit8_i, bit7_i, bit6_i, bit5_i, bit4_i, bit3_i, bit2_i, bit1_i} = c;
    endtask

    task automatic model_add(input logic [7:0] c);
        if (exp_cnt[c] != {CW{1'b1}}) exp_cnt[c] = exp_cnt[c] + 1'b1;
    endtask

    task automatic clear_model;
        for (int i = 0; i < NB; i++) exp_cnt[i] = '0;
    endtask

    // Drive pix[0..n-1] on consecutive cycles with done_i held high.
    task automatic send_codes(input int n);
        for (int i = 0; i < n; i++) begin
            set_code(pix[i]);
            done_i = 1'b1;
            model_add(pix[i]);
            tick;
        end
        done_i = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_o && n < 1000) begin
            tick;
            n++;
        end
        n_checks++;
        if (n !== 256) $display("FAIL %s: ready_o after %0d cycles, want 256", name, n);
        else n_pass++;
    endtask

    // End the frame (optionally with a coincident pixel) and read all bins.
    task automatic read_frame(input int duty, input int coin_code, input bit inject);
        int  n;
        int  k;
        bit  injected;
        injected = 1'b0;
        if (coin_code >= 0) begin
            set_code(coin_code[7:0]);
            done_i = 1'b1;
            model_add(coin_code[7:0]);
        end
        progress_done_i = 1'b1;
        tick;
        progress_done_i = 1'b0;
        done_i = 1'b0;
        n = 1;
        while (!hist_valid_o && n < 10) begin
            tick;
            n++;
        end
        n_checks++;
        if (n !== 4) $display("FAIL first_valid_latency: got %0d cycles, want 4", n);
        else n_pass++;
        for (int b = 0; b < NB; b++) begin
            k = 0;
            while (!hist_valid_o && k < 4) begin
                tick;
                k++;
            end
            n_checks++;
            if (hist_valid_o !== 1'b1) begin
                $display("FAIL bin_valid[%0d]: hist_valid_o=%b, want 1", b, hist_valid_o);
                return;
            end else n_pass++;
            n_checks++;
            if (hist_bin_o !== b[7:0]) $display("FAIL bin_index[%0d]: got %0d, want %0d", b, hist_bin_o, b);
            else n_pass++;
            n_checks++;
            if (hist_count_o !== exp_cnt[b]) $display("FAIL bin_count[%0d]: got %0d, want %0d", b, hist_count_o, exp_cnt[b]);
            else n_pass++;
            n_checks++;
            if (hist_last_o !== (b == NB - 1)) $display("FAIL bin_last[%0d]: got %b, want %b", b, hist_last_o, (b == NB - 1));
            else n_pass++;
            while ((duty < 100 && $urandom_range(0, 99) >= duty) || (inject && b == 3 && !injected)) begin
                hist_ready_i = 1'b0;
                if (inject && b == 3 && !injected) begin
                    n_checks++;
                    if (dropped_o !== 1'b0) $display("FAIL dropped_pre: got %b, want 0", dropped_o);
                    else n_pass++;
                    set_code(8'h03);
                    done_i = 1'b1;
                    progress_done_i = 1'b1;
                    injected = 1'b1;
                end
                tick;
                done_i = 1'b0;
                progress_done_i = 1'b0;
                n_checks++;
                if (hist_valid_o !== 1'b1 || hist_bin_o !== b[7:0] || hist_count_o !== exp_cnt[b])
                    $display("FAIL hold_stable[%0d]: valid=%b bin=%0d count=%0d, want 1/%0d/%0d",
                             b, hist_valid_o, hist_bin_o, hist_count_o, b, exp_cnt[b]);
                else n_pass++;
            end
            hist_ready_i = 1'b1;
            tick;
            hist_ready_i = 1'b0;
            exp_cnt[b] = '0;
            n_checks++;
            if (hist_valid_o !== 1'b0) $display("FAIL valid_drop[%0d]: got %b, want 0", b, hist_valid_o);
            else n_pass++;
            n_checks++;
            if (ready_o !== (b == NB - 1)) $display("FAIL ready_after_hs[%0d]: got %b, want %b", b, ready_o, (b == NB - 1));
            else n_pass++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        clear_model();
        repeat (3) tick;
        n_checks++;
        if ({hist_valid_o, hist_bin_o, hist_count_o, hist_last_o, ready_o, dropped_o} !== '0)
            $display("FAIL reset_outputs: valid=%b bin=%0d count=%0d last=%b ready=%b dropped=%b, want all 0",
                     hist_valid_o, hist_bin_o, hist_count_o, hist_last_o, ready_o, dropped_o);
        else n_pass++;
        rst = 1'b1;
        wait_ready("clear_length");
    endtask

    task automatic test_empty_frame;
        read_frame(100, -1, 1'b0);
    endtask

    task automatic test_triple;
        pix[0] = 8'h05; pix[1] = 8'h05; pix[2] = 8'h05;
        send_codes(3);
        read_frame(100, -1, 1'b0);
    endtask

    task automatic test_bypass;
        pix[0] = 8'h05; pix[1] = 8'h05; pix[2] = 8'h06; pix[3] = 8'h05;
        send_codes(4);
        read_frame(30, -1, 1'b0);
    endtask

    task automatic test_random_ready;
        pix[0] = 8'h80; pix[1] = 8'h01; pix[2] = 8'h80;
        send_codes(1);
        tick;
        set_code(pix[1]);
        done_i = 1'b1;
        model_add(pix[1]);
        tick;
        done_i = 1'b0;
        tick;
        set_code(pix[2]);
        done_i = 1'b1;
        model_add(pix[2]);
        tick;
        done_i = 1'b0;
        read_frame(30, 8'h81, 1'b0);
    endtask

    task automatic test_dropped;
        pix[0] = 8'h03; pix[1] = 8'h40;
        send_codes(2);
        read_frame(30, -1, 1'b1);
        n_checks++;
        if (dropped_o !== 1'b1) $display("FAIL dropped_sticky: got %b, want 1", dropped_o);
        else n_pass++;
        read_frame(100, -1, 1'b0);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 20; i++) pix[i] = 8'hFF;
        pix[20] = 8'hFE;
        send_codes(21);
        read_frame(100, -1, 1'b0);
    endtask

    task automatic test_reset_mid;
        pix[0] = 8'h10; pix[1] = 8'h10; pix[2] = 8'h10;
        send_codes(3);
        rst = 1'b0;
        #2;
        n_checks++;
        if (ready_o !== 1'b0 || dropped_o !== 1'b0 || hist_valid_o !== 1'b0)
            $display("FAIL async_reset: ready=%b dropped=%b valid=%b, want 0/0/0", ready_o, dropped_o, hist_valid_o);
        else n_pass++;
        clear_model();
        tick;
        tick;
        rst = 1'b1;
        wait_ready("clear_length_rerun");
        read_frame(100, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_triple();
        test_bypass();
        test_random_ready();
        test_dropped();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
